// File: rtl/harv_dmem_wb_bridge.sv
// Bridges the harv core req/gnt data port onto a classic Wishbone master, with lane steering and load extension.
// gnt comes 2 cycles after the request is sampled, plus slave wait states; misaligned accesses, slave errors and timeouts return gnt with err.
module harv_dmem_wb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dmem_req_i,
  input  logic                  dmem_wren_i,
  input  logic [1:0]            dmem_ben_i,
  input  logic                  dmem_usgn_i,
  input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [31:0]           dmem_wdata_i,
  output logic                  dmem_gnt_o,
  output logic                  dmem_err_o,
  output logic [31:0]           dmem_rdata_o,
  output logic                  data_mem_cyc_o,
  output logic                  data_mem_stb_o,
  output logic                  data_mem_we_o,
  output logic [3:0]            data_mem_sel_o,
  output logic [ADDR_WIDTH-1:0] data_mem_addr_o,
  output logic [31:0]           data_mem_data_o,
  input  logic [31:0]           data_mem_data_i,
  input  logic                  data_mem_ack_i,
  input  logic                  data_mem_err_i
);

  localparam int unsigned      CNT_W     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    cyc_q, cyc_d;
  logic                    we_q, we_d;
  logic [3:0]              sel_q, sel_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdat_q, wdat_d;
  logic                    usgn_q, usgn_d;
  logic [1:0]              size_q, size_d;
  logic [1:0]              lo_q, lo_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    gnt_q, gnt_d;
  logic                    err_q, err_d;
  logic [31:0]             rdata_q, rdata_d;

  logic                    req_bad;
  logic [3:0]              req_sel;
  logic [31:0]             req_wdat;

  function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [1:0] size,
                                           input logic [1:0] lo, input logic usgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{lo, 3'b000} +: 8];
    h = lo[1] ? d[31:16] : d[15:0];
    case (size)
      2'b00:   load_ext = {{24{~usgn & b[7]}}, b};
      2'b01:   load_ext = {{16{~usgn & h[15]}}, h};
      default: load_ext = d;
    endcase
  endfunction

  always_comb begin
    req_bad  = 1'b0;
    req_sel  = 4'b0000;
    req_wdat = dmem_wdata_i;
    case (dmem_ben_i)
      2'b00: begin
        req_sel  = 4'b0001 << dmem_addr_i[1:0];
        req_wdat = {4{dmem_wdata_i[7:0]}};
      end
      2'b01: begin
        req_bad  = dmem_addr_i[0];
        req_sel  = 4'b0011 << {dmem_addr_i[1], 1'b0};
        req_wdat = {2{dmem_wdata_i[15:0]}};
      end
      2'b10: begin
        req_bad  = (dmem_addr_i[1:0] != 2'b00);
        req_sel  = 4'b1111;
      end
      default: req_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    usgn_d  = usgn_q;
    size_d  = size_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    gnt_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (dmem_req_i) begin
          we_d   = dmem_wren_i;
          usgn_d = dmem_usgn_i;
          size_d = dmem_ben_i;
          lo_d   = dmem_addr_i[1:0];
          sel_d  = req_sel;
          wdat_d = req_wdat;
          addr_d = {dmem_addr_i[ADDR_WIDTH-1:2], 2'b00};
          cnt_d  = '0;
          if (req_bad) begin
            state_d = RESP;
            gnt_d   = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = WAIT_ACK;
            cyc_d   = 1'b1;
          end
        end
      end
      WAIT_ACK: begin
        cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        // ack beats err beats timeout when several land in the same cycle
        if (data_mem_ack_i) begin
          state_d = RESP;
          cyc_d   = 1'b0;
          gnt_d   = 1'b1;
          rdata_d = we_q ? 32'h0 : load_ext(data_mem_data_i, size_q, lo_q, usgn_q);
        end else if (data_mem_err_i ||
                     ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LIMIT))) begin
          state_d = RESP;
          cyc_d   = 1'b0;
          gnt_d   = 1'b1;
          err_d   = 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      usgn_q  <= 1'b0;
      size_q  <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      gnt_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      usgn_q  <= usgn_d;
      size_q  <= size_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign dmem_gnt_o      = gnt_q;
  assign dmem_err_o      = err_q;
  assign dmem_rdata_o    = rdata_q;
  assign data_mem_cyc_o  = cyc_q;
  assign data_mem_stb_o  = cyc_q;
  assign data_mem_we_o   = we_q;
  assign data_mem_sel_o  = sel_q;
  assign data_mem_addr_o = addr_q;
  assign data_mem_data_o = wdat_q;

endmodule

// File: tb/tb_harv_dmem_wb_bridge.sv
// Scoreboard bench for harv_dmem_wb_bridge: the driver queues expected bus and response values, monitors compare.
module tb_harv_dmem_wb_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dmem_req_i, dmem_wren_i, dmem_usgn_i;
  logic [1:0]  dmem_ben_i;
  logic [31:0] dmem_addr_i, dmem_wdata_i;
  logic        dmem_gnt_o, dmem_err_o;
  logic [31:0] dmem_rdata_o;
  logic        data_mem_cyc_o, data_mem_stb_o, data_mem_we_o;
  logic [3:0]  data_mem_sel_o;
  logic [31:0] data_mem_addr_o, data_mem_data_o, data_mem_data_i;
  logic        data_mem_ack_i, data_mem_err_i;

  harv_dmem_wb_bridge #(.TIMEOUT_CYCLES(4), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .dmem_req_i(dmem_req_i), .dmem_wren_i(dmem_wren_i), .dmem_ben_i(dmem_ben_i),
    .dmem_usgn_i(dmem_usgn_i), .dmem_addr_i(dmem_addr_i), .dmem_wdata_i(dmem_wdata_i),
    .dmem_gnt_o(dmem_gnt_o), .dmem_err_o(dmem_err_o), .dmem_rdata_o(dmem_rdata_o),
    .data_mem_cyc_o(data_mem_cyc_o), .data_mem_stb_o(data_mem_stb_o), .data_mem_we_o(data_mem_we_o),
    .data_mem_sel_o(data_mem_sel_o), .data_mem_addr_o(data_mem_addr_o), .data_mem_data_o(data_mem_data_o),
    .data_mem_data_i(data_mem_data_i), .data_mem_ack_i(data_mem_ack_i), .data_mem_err_i(data_mem_err_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic err; logic [31:0] rdata; int t; } resp_t;
  typedef struct { logic [31:0] addr; logic [3:0] sel; logic we; logic [31:0] dat; int len; } bus_t;

  resp_t resp_q[$];
  bus_t  bus_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc_cnt = 0;
  int    s_ack_at = 0, s_err_at = 0, stb_idx = 0;
  logic [31:0] s_data = 32'h0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Slave model: ack/err raised in the configured stb cycle (1-based), never if 0.
  initial begin
    data_mem_ack_i = 1'b0;
    data_mem_err_i = 1'b0;
    data_mem_data_i = 32'h0;
    forever begin
      @(negedge clk);
      if (data_mem_cyc_o) stb_idx++;
      else stb_idx = 0;
      data_mem_ack_i  = data_mem_cyc_o && (s_ack_at != 0) && (stb_idx == s_ack_at);
      data_mem_err_i  = data_mem_cyc_o && (s_err_at != 0) && (stb_idx == s_err_at);
      data_mem_data_i = s_data;
    end
  end

  initial begin : resp_mon
    resp_t r;
    forever begin
      @(negedge clk);
      if (dmem_gnt_o) begin
        if (resp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_gnt: got gnt=1 expected no response at cycle %0d", cyc_cnt);
        end else begin
          r = resp_q.pop_front();
          chk("resp_err", {31'b0, dmem_err_o}, {31'b0, r.err});
          chk("resp_rdata", dmem_rdata_o, r.rdata);
          if (r.t >= 0) chk("gnt_cycle", cyc_cnt, r.t);
        end
      end else begin
        chk("rdata_idle", dmem_rdata_o, 32'h0);
      end
    end
  end

  initial begin : bus_mon
    bus_t cur;
    int   len;
    logic prev;
    prev = 1'b0;
    len = 0;
    cur.len = 0;
    forever begin
      @(negedge clk);
      if (data_mem_cyc_o && !prev) begin
        if (bus_q.size() == 0) begin
          checks++; errors++;
          cur.len = 0;
          $display("FAIL unexpected_cyc: got cyc=1 addr 0x%08h expected no bus cycle", data_mem_addr_o);
        end else begin
          cur = bus_q.pop_front();
          chk("bus_addr", data_mem_addr_o, cur.addr);
          chk("bus_sel", {28'b0, data_mem_sel_o}, {28'b0, cur.sel});
          chk("bus_we", {31'b0, data_mem_we_o}, {31'b0, cur.we});
          chk("bus_data", data_mem_data_o, cur.dat);
          chk("bus_stb", {31'b0, data_mem_stb_o}, 32'h1);
        end
        len = 0;
      end
      if (data_mem_cyc_o) len++;
      if (!data_mem_cyc_o && prev && cur.len != 0) chk("cyc_len", len, cur.len);
      prev = data_mem_cyc_o;
    end
  end

  task automatic do_req(input logic wr, input logic [1:0] ben, input logic usgn,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int ack_at, input int err_at, input logic [31:0] sdata,
                        input logic bus, input logic [31:0] eaddr, input logic [3:0] esel,
                        input logic [31:0] edat, input int elen,
                        input logic eerr, input logic [31:0] erdata, input int elat);
    resp_t r;
    bus_t  b;
    logic  got;
    @(negedge clk);
    s_ack_at = ack_at;
    s_err_at = err_at;
    s_data   = sdata;
    if (bus) begin
      b.addr = eaddr; b.sel = esel; b.we = wr; b.dat = edat; b.len = elen;
      bus_q.push_back(b);
    end
    r.err = eerr; r.rdata = erdata;
    r.t = (elat < 0) ? -1 : cyc_cnt + elat;
    resp_q.push_back(r);
    dmem_wren_i = wr; dmem_ben_i = ben; dmem_usgn_i = usgn;
    dmem_addr_i = addr; dmem_wdata_i = wd; dmem_req_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dmem_gnt_o) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL gnt_timeout: got no gnt expected gnt for addr 0x%08h", addr);
    end
    dmem_req_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    dmem_req_i = 1'b0; dmem_wren_i = 1'b0; dmem_ben_i = 2'b00; dmem_usgn_i = 1'b0;
    dmem_addr_i = 32'h0; dmem_wdata_i = 32'h0;
    #3;
    chk("rst_gnt", {31'b0, dmem_gnt_o}, 32'h0);
    chk("rst_err", {31'b0, dmem_err_o}, 32'h0);
    chk("rst_rdata", dmem_rdata_o, 32'h0);
    chk("rst_cyc", {31'b0, data_mem_cyc_o}, 32'h0);
    chk("rst_stb", {31'b0, data_mem_stb_o}, 32'h0);
    chk("rst_we", {31'b0, data_mem_we_o}, 32'h0);
    chk("rst_sel", {28'b0, data_mem_sel_o}, 32'h0);
    chk("rst_addr", data_mem_addr_o, 32'h0);
    chk("rst_data", data_mem_data_o, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //     wr ben   u  addr          wdata         ack err slave_data     bus eaddr         esel   edata         len err rdata         lat
    do_req(0, 2'b10, 0, 32'h100, 32'h0,         1, 0, 32'hDEADBEEF, 1, 32'h100, 4'hF, 32'h0,        1, 0, 32'hDEADBEEF, 2);
    do_req(0, 2'b00, 0, 32'h103, 32'h0,         1, 0, 32'h80112233, 1, 32'h100, 4'h8, 32'h0,        1, 0, 32'hFFFFFF80, 2);
    do_req(0, 2'b00, 1, 32'h103, 32'h0,         1, 0, 32'h80112233, 1, 32'h100, 4'h8, 32'h0,        1, 0, 32'h00000080, 2);
    do_req(0, 2'b00, 0, 32'h101, 32'h0,         1, 0, 32'h80112233, 1, 32'h100, 4'h2, 32'h0,        1, 0, 32'h00000022, 2);
    do_req(1, 2'b01, 0, 32'h202, 32'h0000ABCD,  1, 0, 32'h12345678, 1, 32'h200, 4'hC, 32'hABCDABCD, 1, 0, 32'h0,        2);
    do_req(0, 2'b01, 0, 32'h102, 32'h0,         1, 0, 32'h80017FFF, 1, 32'h100, 4'hC, 32'h0,        1, 0, 32'hFFFF8001, 2);
    do_req(0, 2'b01, 1, 32'h102, 32'h0,         1, 0, 32'h80017FFF, 1, 32'h100, 4'hC, 32'h0,        1, 0, 32'h00008001, 2);
    do_req(0, 2'b01, 0, 32'h100, 32'h0,         1, 0, 32'h80017FFF, 1, 32'h100, 4'h3, 32'h0,        1, 0, 32'h00007FFF, 2);
    do_req(1, 2'b00, 0, 32'h101, 32'hFFFFFF5A,  1, 0, 32'h12345678, 1, 32'h100, 4'h2, 32'h5A5A5A5A, 1, 0, 32'h0,        2);
    do_req(1, 2'b10, 0, 32'h300, 32'hCAFEF00D,  3, 0, 32'h12345678, 1, 32'h300, 4'hF, 32'hCAFEF00D, 3, 0, 32'h0,        4);
    do_req(0, 2'b10, 0, 32'h101, 32'h0,         1, 0, 32'h12345678, 0, 32'h0,   4'h0, 32'h0,        0, 1, 32'h0,        -1);
    do_req(0, 2'b11, 0, 32'h100, 32'h0,         1, 0, 32'h12345678, 0, 32'h0,   4'h0, 32'h0,        0, 1, 32'h0,        -1);
    do_req(0, 2'b01, 0, 32'h201, 32'h0,         1, 0, 32'h12345678, 0, 32'h0,   4'h0, 32'h0,        0, 1, 32'h0,        -1);
    do_req(0, 2'b10, 0, 32'h400, 32'h0,         0, 0, 32'h11111111, 1, 32'h400, 4'hF, 32'h0,        5, 1, 32'h0,        6);
    do_req(0, 2'b10, 0, 32'h404, 32'h0,         0, 2, 32'h11111111, 1, 32'h404, 4'hF, 32'h0,        2, 1, 32'h0,        3);
    do_req(0, 2'b10, 0, 32'h408, 32'h0,         1, 1, 32'h0BADF00D, 1, 32'h408, 4'hF, 32'h0,        1, 0, 32'h0BADF00D, 2);

    // Abort a stalled load with reset; no response may follow.
    @(negedge clk);
    s_ack_at = 0; s_err_at = 0; s_data = 32'h0;
    begin
      bus_t b;
      b.addr = 32'h40; b.sel = 4'hF; b.we = 1'b0; b.dat = 32'h0; b.len = 0;
      bus_q.push_back(b);
    end
    dmem_wren_i = 1'b0; dmem_ben_i = 2'b10; dmem_usgn_i = 1'b0;
    dmem_addr_i = 32'h40; dmem_wdata_i = 32'h0; dmem_req_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_reset_cyc", {31'b0, data_mem_cyc_o}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cyc", {31'b0, data_mem_cyc_o}, 32'h0);
    chk("arst_stb", {31'b0, data_mem_stb_o}, 32'h0);
    chk("arst_gnt", {31'b0, dmem_gnt_o}, 32'h0);
    dmem_req_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_req(0, 2'b10, 0, 32'h10, 32'h0, 1, 0, 32'h13579BDF, 1, 32'h10, 4'hF, 32'h0, 1, 0, 32'h13579BDF, 2);

    repeat (6) @(negedge clk);
    chk("resp_q_empty", resp_q.size(), 32'h0);
    chk("bus_q_empty", bus_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
